// File: rtl/axi_pkg.sv
// AXI definitions shared by the atomics adapter: ATOP encodings and the
// helper that tells which atomic operations the adapter implements.
package axi_pkg;

  // Full 6-bit ATOP codes for the non-arithmetic atomics
  localparam logic [5:0] ATOP_ATOMICSWAP = 6'b110000;
  localparam logic [5:0] ATOP_ATOMICCMP  = 6'b110001;

  // ATOP[5:4]: atomic kind for the arithmetic family
  localparam logic [1:0] ATOP_ATOMICSTORE = 2'b01;
  localparam logic [1:0] ATOP_ATOMICLOAD  = 2'b10;

  // ATOP[2:0]: arithmetic operation for ATOMICLOAD/ATOMICSTORE
  localparam logic [2:0] ATOP_ADD  = 3'b000;
  localparam logic [2:0] ATOP_CLR  = 3'b001;
  localparam logic [2:0] ATOP_EOR  = 3'b010;
  localparam logic [2:0] ATOP_SET  = 3'b011;
  localparam logic [2:0] ATOP_SMAX = 3'b100;
  localparam logic [2:0] ATOP_SMIN = 3'b101;
  localparam logic [2:0] ATOP_UMAX = 3'b110;
  localparam logic [2:0] ATOP_UMIN = 3'b111;

  // True for every ATOP the adapter can execute; bit 3 (endianness) is
  // don't-care for LOAD/STORE since only little-endian data is handled.
  function automatic logic atop_is_supported(input logic [5:0] op);
    logic ok;
    if ((op == ATOP_ATOMICSWAP) || (op == ATOP_ATOMICCMP)) begin
      ok = 1'b1;
    end else if ((op[5:4] == ATOP_ATOMICLOAD) || (op[5:4] == ATOP_ATOMICSTORE)) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/axi_riscv_amos_alu_pipe_pkg.sv
// Local types and decode helpers for the pipelined AMO ALU.
package axi_riscv_amos_alu_pipe_pkg;
  import axi_pkg::*;

  // Coarse operation class driving the result multiplexer
  typedef enum logic [1:0] {
    AMO_CLASS_SWAP  = 2'd0,
    AMO_CLASS_CMP   = 2'd1,
    AMO_CLASS_ARITH = 2'd2,
    AMO_CLASS_NONE  = 2'd3
  } amo_class_e;

  function automatic amo_class_e amo_classify(input logic [5:0] op);
    amo_class_e cls;
    if (op == ATOP_ATOMICSWAP) begin
      cls = AMO_CLASS_SWAP;
    end else if (op == ATOP_ATOMICCMP) begin
      cls = AMO_CLASS_CMP;
    end else if (atop_is_supported(op)) begin
      cls = AMO_CLASS_ARITH;
    end else begin
      cls = AMO_CLASS_NONE;
    end
    return cls;
  endfunction

  // Signed max/min are the only ops whose operands get sign-extended
  function automatic logic amo_is_signed(input logic [5:0] op);
    return (amo_classify(op) == AMO_CLASS_ARITH) &&
           ((op[2:0] == ATOP_SMAX) || (op[2:0] == ATOP_SMIN));
  endfunction

endpackage

// File: rtl/axi_riscv_amos_alu_core.sv
// Combinational AMO datapath: takes operands already extended to
// DATA_WIDTH+1 bits and produces the new memory value for the active size.
module axi_riscv_amos_alu_core
  import axi_pkg::*;
  import axi_riscv_amos_alu_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [5:0]            op,
  input  logic [2:0]            size,
  input  logic                  err_in,
  input  logic [DATA_WIDTH:0]   operand_a,
  input  logic [DATA_WIDTH:0]   operand_b,
  input  logic [DATA_WIDTH-1:0] operand_c,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err
);

  // Mask of the active bytes for an (already legalised) size
  function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [2:0] sz);
    logic [DATA_WIDTH-1:0] top_bit;
    top_bit = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << ((32'd8 << sz) - 32'd1);
    // at full width the shift wraps to zero and the subtraction gives all ones
    return (top_bit << 1) - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic [DATA_WIDTH-1:0] mask_s;
  logic [DATA_WIDTH-1:0] a_s;
  logic [DATA_WIDTH-1:0] b_s;
  logic [DATA_WIDTH-1:0] raw_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic                  a_lt_b_s;
  logic                  a_eq_b_s;
  amo_class_e            class_s;

  // Decode, compare through the widened subtraction, and select the result
  always_comb begin
    mask_s   = size_mask(size);
    a_s      = operand_a[DATA_WIDTH-1:0];
    b_s      = operand_b[DATA_WIDTH-1:0];
    // operands carry one extra extension bit, so the difference never overflows
    diff_s   = operand_a - operand_b;
    a_lt_b_s = diff_s[DATA_WIDTH];
    a_eq_b_s = (diff_s == {(DATA_WIDTH+1){1'b0}});
    class_s  = amo_classify(op);
    err      = err_in | (class_s == AMO_CLASS_NONE);
    case (class_s)
      AMO_CLASS_SWAP: raw_s = b_s;
      AMO_CLASS_CMP:  raw_s = ((a_s & mask_s) == (operand_c & mask_s)) ? b_s : a_s;
      AMO_CLASS_ARITH: begin
        case (op[2:0])
          ATOP_ADD:             raw_s = a_s + b_s;
          ATOP_CLR:             raw_s = a_s & ~b_s;
          ATOP_EOR:             raw_s = a_s ^ b_s;
          ATOP_SET:             raw_s = a_s | b_s;
          ATOP_SMAX, ATOP_UMAX: raw_s = (a_lt_b_s && !a_eq_b_s) ? b_s : a_s;
          ATOP_SMIN, ATOP_UMIN: raw_s = (a_lt_b_s || a_eq_b_s) ? a_s : b_s;
          default:              raw_s = a_s;
        endcase
      end
      default: raw_s = a_s;
    endcase
    result = (err ? a_s : raw_s) & mask_s;
  end

endmodule

// File: rtl/axi_riscv_amos_alu_pipe.sv
// Two-stage elastic AMO ALU: S1 holds extended operands, S2 holds results.
module axi_riscv_amos_alu_pipe
  import axi_pkg::*;
  import axi_riscv_amos_alu_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [5:0]            amo_op_i,
  input  logic [2:0]            amo_size_i,
  input  logic [DATA_WIDTH-1:0] amo_operand_a_i,
  input  logic [DATA_WIDTH-1:0] amo_operand_b_i,
  input  logic [DATA_WIDTH-1:0] amo_operand_c_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] amo_result_o,
  output logic                  err_o,
  output logic [TAG_WIDTH-1:0]  tag_o
);

  // Reject datapath widths the size decode cannot express
  if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : gen_bad_width
    $error("axi_riscv_amos_alu_pipe: DATA_WIDTH must be a power of two >= 8");
  end

  // Largest AXI size that fits the datapath
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef struct packed {
    logic [5:0]            op;
    logic [2:0]            size;
    logic                  err;
    logic [DATA_WIDTH:0]   a;
    logic [DATA_WIDTH:0]   b;
    logic [DATA_WIDTH-1:0] c;
    logic [TAG_WIDTH-1:0]  tag;
  } s1_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  err;
    logic [TAG_WIDTH-1:0]  tag;
  } s2_t;

  function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [2:0] sz);
    logic [DATA_WIDTH-1:0] top_bit;
    top_bit = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << ((32'd8 << sz) - 32'd1);
    return (top_bit << 1) - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Truncate to the active size and extend by one bit past DATA_WIDTH
  function automatic logic [DATA_WIDTH:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                 input logic [2:0] sz, input logic sgn);
    logic [DATA_WIDTH-1:0] m;
    logic [DATA_WIDTH-1:0] top_bit;
    logic                  sb;
    m       = size_mask(sz);
    top_bit = m & ~(m >> 1);
    sb      = sgn & (|(v & top_bit));
    return {sb, (v & m) | (sb ? ~m : {DATA_WIDTH{1'b0}})};
  endfunction

  s1_t                   s1_r;
  s1_t                   s1_next_s;
  s2_t                   s2_r;
  logic                  s1_valid_r;
  logic                  s2_valid_r;
  logic                  s2_load_s;
  logic                  ready_s;
  logic                  accept_s;
  logic                  size_err_s;
  logic                  sgn_s;
  logic [2:0]            eff_size_s;
  logic [DATA_WIDTH-1:0] core_result_s;
  logic                  core_err_s;

  // Handshake: S2 refills when empty or draining, S1 follows S2
  always_comb begin
    s2_load_s = !s2_valid_r || ready_i;
    ready_s   = !s1_valid_r || s2_load_s;
    accept_s  = valid_i && ready_s;
  end

  // Legalise the size and build the extended operands for S1
  always_comb begin
    size_err_s     = (amo_size_i > MAX_SIZE);
    eff_size_s     = size_err_s ? MAX_SIZE : amo_size_i;
    sgn_s          = amo_is_signed(amo_op_i);
    s1_next_s.op   = amo_op_i;
    s1_next_s.size = eff_size_s;
    s1_next_s.err  = size_err_s | !atop_is_supported(amo_op_i);
    s1_next_s.a    = extend(amo_operand_a_i, eff_size_s, sgn_s);
    s1_next_s.b    = extend(amo_operand_b_i, eff_size_s, sgn_s);
    s1_next_s.c    = amo_operand_c_i & size_mask(eff_size_s);
    s1_next_s.tag  = tag_i;
  end

  axi_riscv_amos_alu_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) i_core (
    .op        (s1_r.op),
    .size      (s1_r.size),
    .err_in    (s1_r.err),
    .operand_a (s1_r.a),
    .operand_b (s1_r.b),
    .operand_c (s1_r.c),
    .result    (core_result_s),
    .err       (core_err_s)
  );

  // S1 register: takes a new operation whenever it is free or advancing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_r <= 1'b0;
      s1_r       <= {$bits(s1_t){1'b0}};
    end else begin
      if (ready_s) begin
        s1_valid_r <= valid_i;
      end
      if (accept_s) begin
        s1_r <= s1_next_s;
      end
    end
  end

  // S2 register: holds the result stable until the consumer takes it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_r <= 1'b0;
      s2_r       <= {$bits(s2_t){1'b0}};
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_r.result <= core_result_s;
        s2_r.err    <= core_err_s;
        s2_r.tag    <= s1_r.tag;
      end
    end
  end

  assign ready_o      = ready_s;
  assign valid_o      = s2_valid_r;
  assign amo_result_o = s2_r.result;
  assign err_o        = s2_r.err;
  assign tag_o        = s2_r.tag;

endmodule

// File: tb/tb_axi_riscv_amos_alu_pipe.sv
// Directed and short random-stream bench for axi_riscv_amos_alu_pipe.
module tb_axi_riscv_amos_alu_pipe;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [5:0]  amo_op_i;
  logic [2:0]  amo_size_i;
  logic [63:0] amo_operand_a_i;
  logic [63:0] amo_operand_b_i;
  logic [63:0] amo_operand_c_i;
  logic [3:0]  tag_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] amo_result_o;
  logic        err_o;
  logic [3:0]  tag_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [63:0] r;
    logic        e;
    logic [3:0]  tag;
  } exp_t;

  axi_riscv_amos_alu_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .amo_op_i(amo_op_i), .amo_size_i(amo_size_i),
    .amo_operand_a_i(amo_operand_a_i), .amo_operand_b_i(amo_operand_b_i),
    .amo_operand_c_i(amo_operand_c_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .amo_result_o(amo_result_o),
    .err_o(err_o), .tag_o(tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Behavioural reference: {err, result}
  function automatic logic [64:0] ref_model(input logic [5:0] op, input logic [2:0] sz,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c);
    logic [63:0] m, am, bm, cm, r;
    logic        e;
    longint      sa, sb;
    int          w;
    w  = 8 << sz;
    m  = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    am = a & m;
    bm = b & m;
    cm = c & m;
    sa = $signed(am << (64 - w)) >>> (64 - w);
    sb = $signed(bm << (64 - w)) >>> (64 - w);
    e  = 1'b0;
    r  = am;
    case (op)
      6'b110000: r = bm;
      6'b110001: r = (am == cm) ? bm : am;
      default: begin
        if ((op[5:4] == 2'b10) || (op[5:4] == 2'b01)) begin
          case (op[2:0])
            3'd0: r = am + bm;
            3'd1: r = am & ~bm;
            3'd2: r = am ^ bm;
            3'd3: r = am | bm;
            3'd4: r = (sa >= sb) ? am : bm;
            3'd5: r = (sa <= sb) ? am : bm;
            3'd6: r = (am >= bm) ? am : bm;
            default: r = (am <= bm) ? am : bm;
          endcase
        end else begin
          e = 1'b1;
        end
      end
    endcase
    return {e, r & m};
  endfunction

  // One isolated operation with ready_i high: checks the 2-cycle latency
  task automatic run_op(input string name, input logic [5:0] op, input logic [2:0] sz,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [3:0] tag, input logic [63:0] er, input logic ee,
                        input logic check_res);
    chk({name, "_ready"}, ready_o, 64'd1);
    ready_i = 1'b1; valid_i = 1'b1; amo_op_i = op; amo_size_i = sz;
    amo_operand_a_i = a; amo_operand_b_i = b; amo_operand_c_i = c; tag_i = tag;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk({name, "_lat1"}, valid_o, 64'd0);
    @(posedge clk_i); #1;
    chk({name, "_valid"}, valid_o, 64'd1);
    if (check_res) chk({name, "_res"}, amo_result_o, er);
    chk({name, "_err"}, err_o, ee);
    chk({name, "_tag"}, tag_o, tag);
    @(posedge clk_i); #1;
    chk({name, "_drain"}, valid_o, 64'd0);
  endtask

  logic [5:0]  s_op [16];
  logic [2:0]  s_sz [16];
  logic [63:0] s_a  [16];
  logic [63:0] s_b  [16];
  logic [63:0] s_c  [16];
  logic [5:0]  op_tab [11];

  initial begin
    exp_t        q[$];
    exp_t        ex;
    logic [64:0] mr;
    logic        prev_hold;
    logic [63:0] held_r;
    logic [3:0]  held_tag;
    int          pushed;
    int          popped;

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; amo_op_i = 6'd0; amo_size_i = 3'd0;
    amo_operand_a_i = 64'd0; amo_operand_b_i = 64'd0; amo_operand_c_i = 64'd0; tag_i = 4'd0;
    #12;
    chk("rst_valid", valid_o, 64'd0);
    chk("rst_ready", ready_o, 64'd1);
    chk("rst_result", amo_result_o, 64'd0);
    chk("rst_err", err_o, 64'd0);
    chk("rst_tag", tag_o, 64'd0);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed vectors
    run_op("smax_b", 6'b100100, 3'd0, 64'h80, 64'h7F, 64'd0, 4'h1, 64'h7F, 1'b0, 1'b1);
    run_op("umax_b", 6'b010110, 3'd0, 64'h80, 64'h7F, 64'd0, 4'h2, 64'h80, 1'b0, 1'b1);
    run_op("smin_trunc", 6'b100101, 3'd0, 64'hAAAA_0000_0000_0080, 64'h7F, 64'd0, 4'h3, 64'h80, 1'b0, 1'b1);
    run_op("add_w32", 6'b100000, 3'd2, 64'hFFFF_FFFF, 64'h1, 64'd0, 4'h4, 64'h0, 1'b0, 1'b1);
    run_op("cmp_hit", 6'b110001, 3'd3, 64'h1234, 64'hBEEF, 64'h1234, 4'h5, 64'hBEEF, 1'b0, 1'b1);
    run_op("cmp_miss", 6'b110001, 3'd3, 64'h1234, 64'hBEEF, 64'h1235, 4'h6, 64'h1234, 1'b0, 1'b1);
    run_op("nonatomic", 6'b000000, 3'd1, 64'hABCD, 64'h5555, 64'd0, 4'h7, 64'hABCD, 1'b1, 1'b1);
    run_op("size4", 6'b100011, 3'd4, 64'hF0, 64'h0, 64'd0, 4'h8, 64'hF0, 1'b1, 1'b1);
    run_op("eor_h", 6'b010010, 3'd1, 64'h1234_F0F0, 64'hFF00, 64'd0, 4'h9, 64'h0FF0, 1'b0, 1'b1);
    run_op("clr_w", 6'b100001, 3'd2, 64'hFFFF_FFFF_1234_5678, 64'hFF, 64'd0, 4'hA, 64'h1234_5600, 1'b0, 1'b1);
    run_op("smin_h", 6'b100101, 3'd1, 64'h8000, 64'h0001, 64'd0, 4'hB, 64'h8000, 1'b0, 1'b1);
    run_op("umin_h", 6'b100111, 3'd1, 64'h8000, 64'h0001, 64'd0, 4'hC, 64'h0001, 1'b0, 1'b1);
    run_op("smax_eq", 6'b100100, 3'd0, 64'h55, 64'h55, 64'd0, 4'hD, 64'h55, 1'b0, 1'b1);
    run_op("add_endian", 6'b101000, 3'd3, 64'd5, 64'd7, 64'd0, 4'hE, 64'd12, 1'b0, 1'b1);
    run_op("swap_d", 6'b110000, 3'd3, 64'd1, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 4'hF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1);
    run_op("bad_op", 6'b110010, 3'd0, 64'h1FF, 64'h3, 64'd0, 4'h0, 64'hFF, 1'b1, 1'b1);
    run_op("umax_d", 6'b100110, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_op("smax_d", 6'b100100, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 4'h2, 64'd0, 1'b0, 1'b1);

    // Random stream with ready_i toggling every 3 cycles
    op_tab = '{6'b110000, 6'b110001, 6'b100000, 6'b010001, 6'b100010, 6'b010011,
               6'b100100, 6'b010101, 6'b100110, 6'b010111, 6'b000000};
    for (int i = 0; i < 16; i++) begin
      s_op[i] = op_tab[$urandom_range(10, 0)];
      s_sz[i] = 3'($urandom_range(3, 0));
      s_a[i]  = {$urandom(), $urandom()};
      s_b[i]  = {$urandom(), $urandom()};
      s_c[i]  = (i % 2 == 0) ? s_a[i] : {$urandom(), $urandom()};
    end
    pushed = 0; popped = 0; prev_hold = 1'b0; held_r = 64'd0; held_tag = 4'd0;
    for (int cyc = 0; cyc < 400 && (pushed < 16 || q.size() != 0); cyc++) begin
      ready_i = (((cyc / 3) % 2) == 0);
      if (pushed < 16) begin
        valid_i = 1'b1; amo_op_i = s_op[pushed]; amo_size_i = s_sz[pushed];
        amo_operand_a_i = s_a[pushed]; amo_operand_b_i = s_b[pushed];
        amo_operand_c_i = s_c[pushed]; tag_i = pushed[3:0];
      end else begin
        valid_i = 1'b0;
      end
      #1;
      chk("stream_ready", ready_o, {63'd0, !((q.size() == 2) && !ready_i)});
      if (prev_hold) begin
        chk("hold_valid", valid_o, 64'd1);
        chk("hold_result", amo_result_o, held_r);
        chk("hold_tag", tag_o, held_tag);
      end
      if (valid_o && ready_i) begin
        chk("stream_nodup", {63'd0, q.size() != 0}, 64'd1);
        if (q.size() != 0) begin
          ex = q.pop_front();
          chk("stream_result", amo_result_o, ex.r);
          chk("stream_err", err_o, ex.e);
          chk("stream_tag", tag_o, ex.tag);
          popped++;
        end
      end
      prev_hold = valid_o && !ready_i;
      held_r    = amo_result_o;
      held_tag  = tag_o;
      if (valid_i && ready_o) begin
        mr = ref_model(s_op[pushed], s_sz[pushed], s_a[pushed], s_b[pushed], s_c[pushed]);
        q.push_back('{r: mr[63:0], e: mr[64], tag: pushed[3:0]});
        pushed++;
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    chk("stream_pushed", pushed, 64'd16);
    chk("stream_popped", popped, 64'd16);
    chk("stream_idle", valid_o, 64'd0);

    // Reset with two operations in flight
    ready_i = 1'b0; valid_i = 1'b1; amo_op_i = 6'b100000; amo_size_i = 3'd0;
    amo_operand_a_i = 64'd1; amo_operand_b_i = 64'd1; tag_i = 4'h3;
    @(posedge clk_i); #1;
    tag_i = 4'h4;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("full_valid", valid_o, 64'd1);
    chk("full_ready", ready_o, 64'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", valid_o, 64'd0);
    chk("arst_ready", ready_o, 64'd1);
    chk("arst_result", amo_result_o, 64'd0);
    chk("arst_tag", tag_o, 64'd0);
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_idle", valid_o, 64'd0);
    run_op("post_rst", 6'b010000, 3'd1, 64'h00FF, 64'h0101, 64'd0, 4'h9, 64'h0200, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
